// File: rtl/fpu_issue_pkg.sv
// Shared types and constants for the FPU issue stage: op record, funct5 encodings, default sizes.
package fpu_issue_pkg;

   localparam int DEF_QDEPTH       = 4;
   localparam int DEF_MAX_INFLIGHT = 8;
   localparam int DEF_TAG_W        = 5;
   // Widest tag the op record can carry; a larger TAG_W needs this widened.
   localparam int TAG_W_MAX        = DEF_TAG_W;

   localparam logic [4:0] FADD  = 5'b00000;
   localparam logic [4:0] FSUB  = 5'b00001;
   localparam logic [4:0] FMUL  = 5'b00010;
   localparam logic [4:0] FDIV  = 5'b00011;
   localparam logic [4:0] FSQRT = 5'b00100;

   typedef struct packed {
      logic [31:0]          x;
      logic [31:0]          y;
      logic [31:0]          z;
      logic [4:0]           funct5;
      logic [2:0]           rm;
      logic [TAG_W_MAX-1:0] rd;
   } fpu_op_t;

endpackage

// File: rtl/fpu_issue_fifo.sv
// Generic synchronous FIFO with combinational head output; no bypass, so full only clears after a pop edge.
module fpu_issue_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             push_ok, pop_ok;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/fpu_issue_unit.sv
// FPU issue stage: operand queue feeding fpu_pipe, in-order tag FIFO, registered writeback.
// Optional FPU_ISSUE_CHECK_EN enables the sticky err flag for orphan results and X funct5.
module fpu_issue_unit
   import fpu_issue_pkg::*;
#(
   parameter int QDEPTH       = DEF_QDEPTH,
   parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
   parameter int TAG_W        = DEF_TAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_x,
   input  logic [31:0]      in_y,
   input  logic [31:0]      in_z,
   input  logic [4:0]       in_funct5,
   input  logic [2:0]       in_rm,
   input  logic [TAG_W-1:0] in_rd,
   output logic             fpu_en,
   output logic [31:0]      fpu_x,
   output logic [31:0]      fpu_y,
   output logic [31:0]      fpu_z,
   output logic [4:0]       fpu_funct5,
   output logic [2:0]       fpu_rm,
   input  logic [31:0]      fpu_res,
   input  logic             fpu_valid,
   output logic             wb_valid,
   output logic [TAG_W-1:0] wb_rd,
   output logic [31:0]      wb_data,
   output logic             busy,
   output logic             err
);
   localparam int CW = $clog2(MAX_INFLIGHT) + 1;

   fpu_op_t          in_op, head_op;
   logic             q_push, q_full, q_empty;
   logic             tag_full, tag_empty, tag_pop, orphan;
   logic [TAG_W-1:0] tag_head;
   logic [CW-1:0]    infl_q, infl_d;
   logic             wb_valid_q, wb_valid_d;
   logic [TAG_W-1:0] wb_rd_q, wb_rd_d;
   logic [31:0]      wb_data_q, wb_data_d;

   always_comb begin
      in_op        = '0;
      in_op.x      = in_x;
      in_op.y      = in_y;
      in_op.z      = in_z;
      in_op.funct5 = in_funct5;
      in_op.rm     = in_rm;
      in_op.rd     = TAG_W_MAX'(in_rd);
   end

   assign in_ready = !q_full;
   assign q_push   = in_valid && !q_full && !flush;
   assign fpu_en   = !q_empty && (infl_q < CW'(MAX_INFLIGHT)) && !tag_full && !flush;

   assign fpu_x      = q_empty ? '0 : head_op.x;
   assign fpu_y      = q_empty ? '0 : head_op.y;
   assign fpu_z      = q_empty ? '0 : head_op.z;
   assign fpu_funct5 = q_empty ? '0 : head_op.funct5;
   assign fpu_rm     = q_empty ? '0 : head_op.rm;

   assign tag_pop = fpu_valid && !tag_empty;
   assign orphan  = fpu_valid && tag_empty;

   fpu_issue_fifo #(.WIDTH($bits(fpu_op_t)), .DEPTH(QDEPTH)) u_op_q (
      .clk(clk), .rst(rst), .clr_i(flush), .push_i(q_push), .pop_i(fpu_en),
      .din_i(in_op), .dout_o(head_op), .full_o(q_full), .empty_o(q_empty)
   );

   fpu_issue_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_INFLIGHT)) u_tag_q (
      .clk(clk), .rst(rst), .clr_i(1'b0), .push_i(fpu_en), .pop_i(tag_pop),
      .din_i(TAG_W'(head_op.rd)), .dout_o(tag_head), .full_o(tag_full), .empty_o(tag_empty)
   );

   always_comb begin
      wb_valid_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      infl_d     = infl_q;
      if (tag_pop) begin
         wb_valid_d = 1'b1;
         wb_rd_d    = tag_head;
         wb_data_d  = fpu_res;
      end
`ifndef FPU_ISSUE_CHECK_EN
      // Orphan results still write back, with a zero tag.
      if (orphan) begin
         wb_valid_d = 1'b1;
         wb_rd_d    = '0;
         wb_data_d  = fpu_res;
      end
`endif
      case ({fpu_en, tag_pop})
         2'b10:   infl_d = infl_q + 1'b1;
         2'b01:   infl_d = infl_q - 1'b1;
         default: infl_d = infl_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         infl_q     <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
      end else begin
         infl_q     <= infl_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
      end
   end

`ifdef FPU_ISSUE_CHECK_EN
   logic err_q, err_d;
   logic funct5_unknown;
`ifndef SYNTHESIS
   assign funct5_unknown = $isunknown(in_funct5);
`else
   assign funct5_unknown = 1'b0;
`endif
   always_comb begin
      err_d = err_q;
      if (orphan || (in_valid && funct5_unknown)) err_d = 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign wb_valid = wb_valid_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;
   assign busy     = !q_empty || (infl_q != '0);

endmodule

// File: tb/tb_fpu_issue_unit.sv
// Bench for fpu_issue_unit: queue-level model plus latency-configurable FPU stand-in, directed scenarios.
module tb_fpu_issue_unit;
   import fpu_issue_pkg::*;

   localparam int QD = 4;
   localparam int MI = 8;
   localparam int TW = 5;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready;
   logic [31:0]   in_x, in_y, in_z;
   logic [4:0]    in_funct5;
   logic [2:0]    in_rm;
   logic [TW-1:0] in_rd;
   logic          fpu_en;
   logic [31:0]   fpu_x, fpu_y, fpu_z;
   logic [4:0]    fpu_funct5;
   logic [2:0]    fpu_rm;
   logic [31:0]   fpu_res;
   logic          fpu_valid, wb_valid;
   logic [TW-1:0] wb_rd;
   logic [31:0]   wb_data;
   logic          busy, err;

   always #5 clk = ~clk;

   fpu_issue_unit #(.QDEPTH(QD), .MAX_INFLIGHT(MI), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_funct5(in_funct5), .in_rm(in_rm), .in_rd(in_rd),
      .fpu_en(fpu_en), .fpu_x(fpu_x), .fpu_y(fpu_y), .fpu_z(fpu_z), .fpu_funct5(fpu_funct5),
      .fpu_rm(fpu_rm), .fpu_res(fpu_res), .fpu_valid(fpu_valid), .wb_valid(wb_valid),
      .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy), .err(err)
   );

   typedef struct {
      logic [31:0]   x, y, z;
      logic [4:0]    f;
      logic [2:0]    rm;
      logic [TW-1:0] rd;
   } op_t;
   typedef struct {
      int          due;
      logic [31:0] res;
   } pend_t;

   // Model state: pending ops, tags in flight, FPU results in transit, writeback registers.
   op_t           mq[$];
   logic [TW-1:0] tq[$];
   pend_t         pend[$];
   logic          m_wbv, m_err;
   logic [TW-1:0] m_wbrd;
   logic [31:0]   m_wbd;

   int  errors = 0, checks = 0, cyc = 0, lat = 2;
   bit  hold = 0;
   op_t drv_op;
   bit  drv_valid = 0, drv_flush = 0, drv_rst = 1;
   bit  last_accept, ready_low_seen, both_seen, stall_seen;
   int  dut_en_cnt, dut_val_cnt, max_infl;
   logic [TW-1:0] log_rd[$];
   logic [31:0]   log_data[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // FPU stand-in: exact for 1.0+2.0, otherwise an arbitrary operand mix.
   function automatic logic [31:0] fpu_result(input op_t o);
      if (o.f == FADD && o.x == 32'h3F80_0000 && o.y == 32'h4000_0000) return 32'h4040_0000;
      return o.x ^ {o.y[15:0], o.y[31:16]} ^ o.z;
   endfunction

   function automatic op_t mk(input logic [TW-1:0] rd, input logic [31:0] x);
      op_t o;
      o.x = x; o.y = x + 32'h11; o.z = ~x; o.f = FMUL; o.rm = rd[2:0]; o.rd = rd;
      return o;
   endfunction

   task automatic tick();
      bit          fv, e_ready, e_en, accept;
      logic [31:0] res;
      op_t         h;
      @(negedge clk);
      rst = drv_rst; flush = drv_flush; in_valid = drv_valid;
      in_x = drv_op.x; in_y = drv_op.y; in_z = drv_op.z;
      in_funct5 = drv_op.f; in_rm = drv_op.rm; in_rd = drv_op.rd;
      fv = !hold && pend.size() > 0 && pend[0].due <= cyc;
      fpu_valid = fv;
      fpu_res = fv ? pend[0].res : 32'h0;
      #1;
      e_ready = mq.size() < QD;
      e_en = mq.size() > 0 && tq.size() < MI && !drv_flush;
      last_accept = 0;
      if (!drv_rst) begin
         check("in_ready", 32'(in_ready), 32'(e_ready));
         check("fpu_en", 32'(fpu_en), 32'(e_en));
         check("fpu_x", fpu_x, mq.size() > 0 ? mq[0].x : 32'h0);
         check("fpu_y", fpu_y, mq.size() > 0 ? mq[0].y : 32'h0);
         check("fpu_z", fpu_z, mq.size() > 0 ? mq[0].z : 32'h0);
         check("fpu_funct5", 32'(fpu_funct5), mq.size() > 0 ? 32'(mq[0].f) : 32'h0);
         check("fpu_rm", 32'(fpu_rm), mq.size() > 0 ? 32'(mq[0].rm) : 32'h0);
         check("wb_valid", 32'(wb_valid), 32'(m_wbv));
         check("wb_rd", 32'(wb_rd), 32'(m_wbrd));
         check("wb_data", wb_data, m_wbd);
         check("busy", 32'(busy), 32'(mq.size() > 0 || tq.size() > 0));
         check("err", 32'(err), 32'(m_err));
         if (in_valid && !in_ready) ready_low_seen = 1;
         if (fpu_en && fpu_valid) both_seen = 1;
         if (!fpu_en && mq.size() > 0 && !drv_flush) stall_seen = 1;
         if (wb_valid) begin
            log_rd.push_back(wb_rd);
            log_data.push_back(wb_data);
         end
         if (fpu_en) dut_en_cnt++;
         if (fv) dut_val_cnt++;
         if (dut_en_cnt - dut_val_cnt > max_infl) max_infl = dut_en_cnt - dut_val_cnt;
         last_accept = in_valid && in_ready && !drv_flush;
      end
      if (drv_rst) begin
         mq.delete(); tq.delete(); pend.delete();
         m_wbv = 0; m_wbrd = '0; m_wbd = '0; m_err = 0;
      end else begin
         accept = drv_valid && e_ready && !drv_flush;
         if (fv) begin
            res = pend[0].res;
            void'(pend.pop_front());
            if (tq.size() > 0) begin
               m_wbv = 1; m_wbrd = tq.pop_front(); m_wbd = res;
            end else begin
`ifdef FPU_ISSUE_CHECK_EN
               m_err = 1; m_wbv = 0;
`else
               m_wbv = 1; m_wbrd = '0; m_wbd = res;
`endif
            end
         end else begin
            m_wbv = 0;
         end
         if (e_en) begin
            h = mq.pop_front();
            tq.push_back(h.rd);
            pend.push_back('{cyc + lat, fpu_result(h)});
         end
         if (drv_flush) mq.delete();
         else if (accept) mq.push_back(drv_op);
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic send(input op_t o);
      bit ok = 0;
      drv_op = o;
      drv_valid = 1;
      for (int i = 0; i < 40 && !ok; i++) begin
         tick();
         ok = last_accept;
      end
      if (!ok) check("send_timeout", 32'd0, 32'd1);
      drv_valid = 0;
   endtask

   task automatic drain(input int max_cycles);
      bit done = 0;
      for (int i = 0; i < max_cycles && !done; i++) begin
         if (mq.size() == 0 && tq.size() == 0 && pend.size() == 0 && !m_wbv) done = 1;
         else tick();
      end
      if (!done) check("drain_timeout", 32'd0, 32'd1);
   endtask

   task automatic clear_logs();
      log_rd.delete(); log_data.delete();
      ready_low_seen = 0; both_seen = 0; stall_seen = 0;
      dut_en_cnt = 0; dut_val_cnt = 0; max_infl = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      op_t o;
      drv_op = mk('0, 32'h0);
      m_wbv = 0; m_wbrd = '0; m_wbd = '0; m_err = 0;
      tick(); tick();
      drv_rst = 0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_fpu_en", 32'(fpu_en), 32'd0);
      check("rst_fpu_x", fpu_x, 32'h0);
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_wb_rd", 32'(wb_rd), 32'd0);
      check("rst_wb_data", wb_data, 32'h0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);

      // 1: single fadd 1.0 + 2.0
      clear_logs(); lat = 2;
      o.x = 32'h3F80_0000; o.y = 32'h4000_0000; o.z = 32'h0; o.f = FADD; o.rm = 3'd0; o.rd = 5'd3;
      send(o);
      #1 check("t1_issue_next_cycle", 32'(fpu_en), 32'd1);
      drain(30);
      check("t1_wb_count", 32'(log_rd.size()), 32'd1);
      if (log_rd.size() == 1) begin
         check("t1_wb_rd", 32'(log_rd[0]), 32'd3);
         check("t1_wb_data", log_data[0], 32'h4040_0000);
      end

      // 2: fill 8 in flight with results held, then queue fills at 4 and back-pressures
      clear_logs(); lat = 4; hold = 1;
      for (int i = 0; i < 8; i++) send(mk(TW'(10 + i), 32'h1000 + 32'(i)));
      for (int i = 1; i <= 4; i++) send(mk(TW'(i), 32'h2000 + 32'(i)));
      drv_op = mk(5'd5, 32'h2005); drv_valid = 1;
      repeat (3) tick();
      check("t2_in_ready_low", 32'(ready_low_seen), 32'd1);
      check("t2_no_accept_when_full", 32'(last_accept), 32'd0);
      hold = 0;
      send(mk(5'd5, 32'h2005));
      send(mk(5'd6, 32'h2006));
      drain(200);
      check("t2_wb_count", 32'(log_rd.size()), 32'd14);
      if (log_rd.size() == 14)
         for (int i = 0; i < 14; i++)
            check("t2_wb_order", 32'(log_rd[i]), i < 8 ? 32'(10 + i) : 32'(i - 7));

      // 3/4: FPU latency 10 exceeds the in-flight cap
      clear_logs(); lat = 10;
      for (int i = 0; i < 12; i++) send(mk(TW'(20 + i), 32'h3000 + 32'(i)));
      drain(300);
      check("t3_max_inflight", 32'(max_infl), 32'd8);
      check("t3_stall_seen", 32'(stall_seen), 32'd1);
      check("t4_issue_and_complete_same_cycle", 32'(both_seen), 32'd1);
      check("t3_wb_count", 32'(log_rd.size()), 32'd12);
      if (log_rd.size() == 12)
         for (int i = 0; i < 12; i++) check("t3_wb_order", 32'(log_rd[i]), 32'(20 + i));

      // 5: flush with ops queued behind a full in-flight window
      clear_logs(); lat = 3; hold = 1;
      for (int i = 0; i < 8; i++) send(mk(TW'(8 + i), 32'h4000 + 32'(i)));
      for (int i = 1; i <= 3; i++) send(mk(TW'(i), 32'h5000 + 32'(i)));
      drv_flush = 1; tick(); drv_flush = 0;
      #1;
      check("t5_in_ready_after_flush", 32'(in_ready), 32'd1);
      check("t5_queue_empty_after_flush", 32'(fpu_en), 32'd0);
      check("t5_busy_with_inflight", 32'(busy), 32'd1);
      hold = 0;
      drain(100);
      check("t5_wb_count", 32'(log_rd.size()), 32'd8);
      if (log_rd.size() == 8)
         for (int i = 0; i < 8; i++) check("t5_wb_rd", 32'(log_rd[i]), 32'(8 + i));
      #1 check("t5_busy_dropped", 32'(busy), 32'd0);

      // 6: reset mid-stream, then a stray result
      clear_logs(); lat = 2; hold = 1;
      send(mk(5'd7, 32'h6000));
      send(mk(5'd9, 32'h6001));
      drv_rst = 1; tick(); drv_rst = 0;
      pend.push_back('{cyc, 32'hDEAD_BEEF});
      hold = 0;
      tick();
      tick();
      #1;
`ifdef FPU_ISSUE_CHECK_EN
      check("t6_err_set", 32'(err), 32'd1);
      check("t6_no_wb", 32'(wb_valid), 32'd0);
`else
      check("t6_err_zero", 32'(err), 32'd0);
      check("t6_orphan_wb", 32'(log_rd.size()), 32'd1);
      if (log_rd.size() == 1) begin
         check("t6_orphan_rd", 32'(log_rd[0]), 32'd0);
         check("t6_orphan_data", log_data[0], 32'hDEAD_BEEF);
      end
`endif
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
